// File: rtl/flag_pkg.sv
// Shared flag type, branch condition codes and the condition evaluator
// used by flag_controller.
package flag_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
  } flags_t;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_MI = 4'd2;
  localparam logic [3:0] CC_PL = 4'd3;
  localparam logic [3:0] CC_VS = 4'd4;
  localparam logic [3:0] CC_VC = 4'd5;
  localparam logic [3:0] CC_GE = 4'd6;
  localparam logic [3:0] CC_LT = 4'd7;
  localparam logic [3:0] CC_GT = 4'd8;
  localparam logic [3:0] CC_LE = 4'd9;
  localparam logic [3:0] CC_AL = 4'd10;
  localparam logic [3:0] CC_NV = 4'd11;  // codes 11..15 all mean "never"

  function automatic logic cond_eval(input flags_t f, input logic [3:0] cond);
    logic res;
    res = 1'b0;
    case (cond)
      CC_EQ:   res = f.z;
      CC_NE:   res = !f.z;
      CC_MI:   res = f.n;
      CC_PL:   res = !f.n;
      CC_VS:   res = f.v;
      CC_VC:   res = !f.v;
      CC_GE:   res = (f.n == f.v);
      CC_LT:   res = (f.n != f.v);
      CC_GT:   res = !f.z && (f.n == f.v);
      CC_LE:   res = f.z || (f.n != f.v);
      CC_AL:   res = 1'b1;
      CC_NV:   res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/flag_controller_stack.sv
// LIFO of saved flag sets. Callers present only legal push/pop requests;
// protocol checking lives in flag_controller.
module flag_controller_stack
  import flag_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  flags_t push_data,
  output flags_t top_data,
  output logic   full,
  output logic   empty
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  flags_t          slot_q [STACK_DEPTH];
  logic [SP_W-1:0] sp_q;
  logic [SP_W-1:0] sp_d;
  logic [SP_W-1:0] sp_m1;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign sp_m1  = sp_q - SP_W'(1);
  assign wr_idx = sp_q[IDX_W-1:0];
  assign rd_idx = sp_m1[IDX_W-1:0];

  assign top_data = slot_q[rd_idx];
  assign full     = (sp_q == SP_W'(STACK_DEPTH));
  assign empty    = (sp_q == '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sp_d = sp_q;
    if (push && !full)      sp_d = sp_q + SP_W'(1);
    else if (pop && !empty) sp_d = sp_m1;
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  // NOTE: slot storage is deliberately unreset; sp=0 makes its contents unreachable.
  always_ff @(posedge clk) begin
    if (push && !full) slot_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/flag_controller.sv
// Owner of the N/Z/V status flags: ALU capture, branch condition evaluation
// and interrupt save/restore stack. Define FLAG_FWD_EN to evaluate cond_true
// against the next-flag value (same-cycle compare-and-branch).
module flag_controller
  import flag_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_valid,
  input  logic       upd_en,
  input  logic       n_in,
  input  logic       z_in,
  input  logic       v_in,
  input  logic       flag_clr,
  input  logic [3:0] cond,
  input  logic       push_req,
  input  logic       pop_req,
  input  logic       err_clr,
  output logic       n_out,
  output logic       z_out,
  output logic       v_out,
  output logic       cond_true,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       err
);

  flags_t flags_q, flags_d;
  flags_t top_data;
  logic   err_q, err_d;
  logic   push_ok, pop_ok, err_evt;

  // Simultaneous push and pop cancel each other and count as an error.
  assign push_ok = push_req && !pop_req && !stack_full;
  assign pop_ok  = pop_req && !push_req && !stack_empty;
  assign err_evt = (push_req && pop_req)
                || (push_req && !pop_req && stack_full)
                || (pop_req && !push_req && stack_empty);

  flag_controller_stack #(
    .STACK_DEPTH(STACK_DEPTH),
    .SP_W       (SP_W)
  ) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_ok),
    .pop      (pop_ok),
    .push_data(flags_q),
    .top_data (top_data),
    .full     (stack_full),
    .empty    (stack_empty)
  );

  always_comb begin
    flags_d = flags_q;
    if (pop_ok)                      flags_d = top_data;
    else if (flag_clr)               flags_d = '0;
    else if (alu_valid && upd_en)    flags_d = '{n: n_in, z: z_in, v: v_in};

    err_d = err_q;
    if (err_evt)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign n_out = flags_q.n;
  assign z_out = flags_q.z;
  assign v_out = flags_q.v;
  assign err   = err_q;

`ifdef FLAG_FWD_EN
  assign cond_true = cond_eval(flags_d, cond);
`else
  assign cond_true = cond_eval(flags_q, cond);
`endif

endmodule
